// File: rtl/dac_seq_ctrl.sv
// dac_seq_ctrl: power-up / mute / config sequencer for the DAC datapath.
// It brings the downstream datapath out of reset and lets it settle on
// zero data. It then ramps a 0..256 gain up to unity and ramps it back down
// before muting, power-down or a bypass config change. This keeps the
// output free of clicks.
module dac_seq_ctrl #(
  parameter int RST_CYC      = 16,
  parameter int SETTLE_TICKS = 256,
  parameter int RAMP_STEP    = 1
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               en,
  input  logic               mute_req,
  input  logic               tick,
  input  logic               ISI_SEL_req,
  input  logic               MIS_SEL_req,
  input  logic signed [23:0] Data_in,
  output logic signed [23:0] Data_out,
  output logic               dp_rstn,
  output logic               ISI_SEL,
  output logic               MIS_SEL,
  output logic [2:0]         state,
  output logic               busy
);

  localparam int DATA_W = 24;
  localparam int COEF_W = 9;
  localparam int CNT_W  = 16;

  localparam logic [2:0] ST_OFF       = 3'd0;
  localparam logic [2:0] ST_DPRST     = 3'd1;
  localparam logic [2:0] ST_SETTLE    = 3'd2;
  localparam logic [2:0] ST_RAMP_UP   = 3'd3;
  localparam logic [2:0] ST_PLAY      = 3'd4;
  localparam logic [2:0] ST_RAMP_DOWN = 3'd5;
  localparam logic [2:0] ST_MUTED     = 3'd6;

  localparam logic [COEF_W-1:0] UNITY       = 9'd256;
  localparam logic [COEF_W:0]   STEP        = 10'(RAMP_STEP);
  localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);

  logic [2:0]          state_q;
  logic [2:0]          state_d;
  logic [COEF_W-1:0]   gain_q;
  logic [COEF_W-1:0]   gain_d;
  logic [COEF_W-1:0]   gain_up;
  logic [COEF_W-1:0]   gain_dn;
  logic [CNT_W-1:0]    cyc_cnt_q;
  logic [CNT_W-1:0]    tick_cnt_q;
  logic                isi_q;
  logic                mis_q;
  logic                exit_req;
  logic                sel_load;
  logic signed [DATA_W-1:0] data_p1;

  // Gain multiply: signed sample times unsigned gain, arithmetic shift by 8
  // (floor), keep the low 24 bits. |gain| <= 256 so the result cannot overflow.
  function automatic logic signed [DATA_W-1:0] scale(
    input logic signed [DATA_W-1:0] din,
    input logic [COEF_W-1:0]        g
  );
    logic signed [DATA_W+COEF_W-1:0] prod;
    prod = din * $signed({1'b0, g});
    return DATA_W'(prod >>> 8);
  endfunction

  // Gain step toward unity, saturating at 256.
  function automatic logic [COEF_W-1:0] gain_inc(input logic [COEF_W-1:0] g);
    logic [COEF_W:0] sum;
    sum = {1'b0, g} + STEP;
    if (sum >= {1'b0, UNITY}) return UNITY;
    return sum[COEF_W-1:0];
  endfunction

  // Gain step toward zero, saturating at 0.
  function automatic logic [COEF_W-1:0] gain_dec(input logic [COEF_W-1:0] g);
    if ({1'b0, g} <= STEP) return '0;
    return g - STEP[COEF_W-1:0];
  endfunction

  assign gain_up = gain_inc(gain_q);
  assign gain_dn = gain_dec(gain_q);

  // Any of these while audible forces a ramp-down before anything else changes.
  assign exit_req = !en || mute_req ||
                    (ISI_SEL_req != isi_q) || (MIS_SEL_req != mis_q);

  // Bypass config may only change while the gain is held at zero.
  assign sel_load = (state_q == ST_OFF)    || (state_q == ST_DPRST) ||
                    (state_q == ST_SETTLE) || (state_q == ST_MUTED);

  // State register with gain, residency counters and applied config.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= ST_OFF;
      gain_q     <= '0;
      cyc_cnt_q  <= '0;
      tick_cnt_q <= '0;
      isi_q      <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      if (state_d != state_q) begin
        cyc_cnt_q  <= '0;
        tick_cnt_q <= '0;
      end else begin
        if (state_q == ST_DPRST)
          cyc_cnt_q <= cyc_cnt_q + 1'b1;
        if ((state_q == ST_SETTLE) && tick)
          tick_cnt_q <= tick_cnt_q + 1'b1;
      end
      if (sel_load) begin
        isi_q <= ISI_SEL_req;
        mis_q <= MIS_SEL_req;
      end
    end
  end

  // Next-state and next-gain decode.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    case (state_q)
      ST_OFF: begin
        gain_d = '0;
        if (en) state_d = ST_DPRST;
      end
      ST_DPRST: begin
        gain_d = '0;
        if (!en)                         state_d = ST_OFF;
        else if (cyc_cnt_q == RST_LAST)  state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        gain_d = '0;
        if (!en)
          state_d = ST_OFF;
        else if (tick && (tick_cnt_q == SETTLE_LAST))
          state_d = mute_req ? ST_MUTED : ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        // An exit request wins over a same-cycle tick: gain is frozen.
        if (exit_req) begin
          state_d = ST_RAMP_DOWN;
        end else if (tick) begin
          gain_d = gain_up;
          if (gain_up == UNITY) state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        gain_d = UNITY;
        if (exit_req) state_d = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
        // Entered with zero gain (exit right after ramp-up start): leave at once.
        if (gain_q == '0) begin
          state_d = en ? ST_MUTED : ST_OFF;
        end else if (tick) begin
          gain_d = gain_dn;
          if (gain_dn == '0) state_d = en ? ST_MUTED : ST_OFF;
        end
      end
      ST_MUTED: begin
        gain_d = '0;
        if (!en)           state_d = ST_OFF;
        else if (!mute_req) state_d = ST_RAMP_UP;
      end
      default: begin
        state_d = ST_OFF;
        gain_d  = '0;
      end
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    dp_rstn = 1'b0;
    busy    = 1'b0;
    case (state_q)
      ST_DPRST:     busy = 1'b1;
      ST_SETTLE:    begin dp_rstn = 1'b1; busy = 1'b1; end
      ST_RAMP_UP:   begin dp_rstn = 1'b1; busy = 1'b1; end
      ST_PLAY:      dp_rstn = 1'b1;
      ST_RAMP_DOWN: begin dp_rstn = 1'b1; busy = 1'b1; end
      ST_MUTED:     dp_rstn = 1'b1;
      default:      begin dp_rstn = 1'b0; busy = 1'b0; end
    endcase
  end

  // Stage p1: gain-scaled sample, one clock behind Data_in.
  always_ff @(posedge clock) begin
    if (rst) data_p1 <= '0;
    else     data_p1 <= scale(Data_in, gain_q);
  end

  assign Data_out = data_p1;
  assign state    = state_q;
  assign ISI_SEL  = isi_q;
  assign MIS_SEL  = mis_q;

endmodule

// File: doc/dac_seq_ctrl.md
DAC_SEQ_CTRL -- requirements
Module: dac_seq_ctrl

Interface
REQ-001 SHALL have parameter RST_CYC, default 16, meaning clock cycles dp_rstn is held low after enable.
REQ-002 SHALL have parameter SETTLE_TICKS, default 256, meaning sample ticks of zero data after dp_rstn release.
REQ-003 SHALL have parameter RAMP_STEP, default 1, meaning gain change per sample tick (1..256).
REQ-004 SHALL have port clock  in  1  sole clock (sample-rate domain); all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  in  1  play request; 0 means power down.
REQ-007 SHALL have port mute_req  in  1  soft-mute request.
REQ-008 SHALL have port tick  in  1  one-cycle sample strobe; ramp/settle advance only on tick.
REQ-009 SHALL have port ISI_SEL_req, MIS_SEL_req  in  1 each  requested bypass config (0 = bypass).
REQ-010 SHALL have port Data_in  in  24 signed  PCM sample.
REQ-011 SHALL have port Data_out  out  24 signed  gain-scaled sample to interpolator.
REQ-012 SHALL have port dp_rstn  out  1  active-low reset to downstream datapath.
REQ-013 SHALL have port ISI_SEL, MIS_SEL  out  1 each  applied bypass config.
REQ-014 SHALL have ports state  out  3  current state code; busy  out  1  sequencing in progress.

Function
REQ-015 SHALL implement states OFF=0, DPRST=1, SETTLE=2, RAMP_UP=3, PLAY=4, RAMP_DOWN=5, MUTED=6; state output equals code.
REQ-016 SHALL keep a gain register, 9-bit unsigned, range 0..256; 256 = unity.
REQ-017 SHALL register Data_out = (Data_in * gain) >>> 8, signed 33-bit product, arithmetic shift (truncation toward -inf), low 24 bits; latency 1 clock; no overflow possible.
REQ-018 SHALL produce Data_out == Data_in (delayed 1) when gain = 256, and 0 when gain = 0.
REQ-019 OFF: dp_rstn=0, gain=0; en=1 -> DPRST.
REQ-020 DPRST: dp_rstn=0; after RST_CYC clocks in state -> SETTLE; en=0 -> OFF.
REQ-021 SETTLE: dp_rstn=1, gain=0; after SETTLE_TICKS ticks -> MUTED if mute_req else RAMP_UP; en=0 -> OFF.
REQ-022 RAMP_UP: per tick gain = min(gain+RAMP_STEP, 256); on gain reaching 256 -> PLAY.
REQ-023 PLAY: gain held at 256.
REQ-024 RAMP_UP/PLAY exit: en=0, mute_req=1, or (ISI_SEL_req,MIS_SEL_req) != (ISI_SEL,MIS_SEL) -> RAMP_DOWN, taking priority over a same-cycle tick (gain not incremented that cycle).
REQ-025 RAMP_DOWN: per tick gain = max(gain-RAMP_STEP, 0); on the edge gain reaches 0 -> OFF if en=0 else MUTED; requests changing during ramp-down do not reverse it.
REQ-026 MUTED: gain=0, dp_rstn=1; en=0 -> OFF; else mute_req=0 -> RAMP_UP; minimum residency 1 clock.
REQ-027 ISI_SEL/MIS_SEL SHALL load from the _req inputs only in OFF, DPRST, SETTLE and MUTED (gain=0), 1-clock latency; held otherwise.
REQ-028 busy SHALL be 1 in DPRST, SETTLE, RAMP_UP, RAMP_DOWN; 0 in OFF, PLAY, MUTED.
REQ-029 Cycle and tick counters SHALL clear on every state entry.
REQ-030 Undefined state codes SHALL go to OFF next clock.

Reset
REQ-031 rst=1 at a rising edge SHALL set state=OFF, gain=0, Data_out=0, dp_rstn=0, ISI_SEL=0, MIS_SEL=0, busy=0, counters=0.
REQ-032 rst SHALL override all inputs, including mid-ramp; no gradual ramp on reset.
REQ-033 After rst deasserts, block SHALL remain in OFF until en=1.

Verification
REQ-034 Power-up: en=1, mute_req=0, tick every 8 clocks, defaults -> dp_rstn rises 16 clocks after DPRST entry; PLAY reached after 256+256 ticks; Data_in=0x400000 gives Data_out=0x400000.
REQ-035 Ramp arithmetic: gain=128, Data_in=-3 -> Data_out=-2; Data_in=0x7FFFFF -> 0x3FFFFF.
REQ-036 Config change in PLAY: ISI_SEL_req 0->1 -> RAMP_DOWN, 256 ticks to MUTED, ISI_SEL=1 one clock later, RAMP_UP back to PLAY; ISI_SEL never changes while gain != 0.
REQ-037 Mute/en drop: mute_req=1 mid RAMP_UP at gain=100 with tick same cycle -> RAMP_DOWN, gain stays 100 then 99 on next tick; en=0 at gain 0 -> OFF, dp_rstn=0.
REQ-038 Reset mid-operation: rst=1 in PLAY with gain=256 -> next clock all outputs at reset values, state=0.
REQ-039 Edge: RAMP_STEP=256 -> ramp completes in one tick; en toggled 1->0 during SETTLE -> OFF immediately, dp_rstn=0.
